// File: rtl/ddr_read_burst_arbiter.sv
// Multi-channel AXI4 INCR-burst read master for the MIG UI domain: round-robin AR
// arbitration with outstanding-burst credits and per-beat R routing by ID.
module ddr_read_burst_arbiter #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 27,
    parameter int NUM_CH    = 2,
    parameter int BURST_LEN = 8,
    parameter int MAX_OUT   = 4,
    parameter int ID_W      = 4,
    localparam int SZ       = $clog2(DATA_W / 8),
    localparam int WA       = ADDR_W - SZ
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 calib_done_in,
    input  logic [NUM_CH-1:0]    rd_req_valid_in,
    output logic [NUM_CH-1:0]    rd_req_ready_out,
    input  logic [NUM_CH*WA-1:0] rd_req_addr_in,
    output logic [DATA_W-1:0]    rd_data_out,
    output logic [NUM_CH-1:0]    rd_data_valid_out,
    input  logic [NUM_CH-1:0]    rd_data_ready_in,
    output logic                 rd_data_last_out,
    output logic [15:0]          rd_err_count_out,
    output logic [ID_W-1:0]      m_axi_arid,
    output logic [ADDR_W-1:0]    m_axi_araddr,
    output logic [7:0]           m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [ID_W-1:0]      m_axi_rid,
    input  logic [DATA_W-1:0]    m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rlast,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    localparam int BL_W  = $clog2(BURST_LEN);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [WA-1:0]    ALIGN_MASK = ~WA'((1 << BL_W) - 1);
    localparam logic [OUT_W-1:0] MAX_OUT_V  = OUT_W'(MAX_OUT);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_t;

    ar_state_t          state_r;
    ar_state_t          state_nx_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   grant_r;
    logic [OUT_W-1:0]   outstanding_r;
    logic               arvalid_r;
    logic [ADDR_W-1:0]  araddr_r;
    logic [ID_W-1:0]    arid_r;
    logic [15:0]        err_cnt_r;
    logic               arb_en_r;

    logic [PTR_W-1:0]   grant_s;
    logic               grant_found_s;
    logic               grant_en_s;
    logic [WA-1:0]      grant_addr_s;
    logic [NUM_CH-1:0]  req_ready_s;
    logic               ar_hs_s;
    logic [NUM_CH-1:0]  rid_onehot_s;
    logic               rid_legal_s;
    logic               rready_s;
    logic               r_hs_s;
    logic               r_last_hs_s;
    logic               r_err_s;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx           = 0;
        grant_found_s = 1'b0;
        grant_s       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr_r) + k) % NUM_CH;
            if (!grant_found_s && rd_req_valid_in[idx]) begin
                grant_found_s = 1'b1;
                grant_s       = PTR_W'(idx);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_addr_s = rd_req_addr_in[int'(grant_s)*WA +: WA];
    end

    // AR FSM next state and grant decision.
    always_comb begin
        state_nx_s = state_r;
        grant_en_s = 1'b0;
        case (state_r)
            AR_IDLE: begin
                if (arb_en_r && calib_done_in && (outstanding_r < MAX_OUT_V) && grant_found_s) begin
                    grant_en_s = 1'b1;
                    state_nx_s = AR_WAIT;
                end else begin
                    state_nx_s = AR_IDLE;
                end
            end
            AR_WAIT: begin
                if (m_axi_arready) begin
                    state_nx_s = AR_IDLE;
                end else begin
                    state_nx_s = AR_WAIT;
                end
            end
            default: state_nx_s = AR_IDLE;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready_s[i] = grant_en_s && (grant_s == PTR_W'(i));
        end
    end

    // AR FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= AR_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Arbitration is held off for the first cycle after reset release.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            arb_en_r <= 1'b0;
        end else begin
            arb_en_r <= 1'b1;
        end
    end

    assign ar_hs_s = arvalid_r && m_axi_arready;

    // AR channel registers and round-robin pointer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            arvalid_r <= 1'b0;
            araddr_r  <= '0;
            arid_r    <= '0;
            grant_r   <= '0;
            rr_ptr_r  <= '0;
        end else if (grant_en_s) begin
            arvalid_r <= 1'b1;
            araddr_r  <= ADDR_W'(grant_addr_s & ALIGN_MASK) << SZ;
            arid_r    <= ID_W'(grant_s);
            grant_r   <= grant_s;
        end else if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            rr_ptr_r  <= (int'(grant_r) == NUM_CH - 1) ? '0 : grant_r + PTR_W'(1);
        end else begin
            arvalid_r <= arvalid_r;
        end
    end

    // Zero-latency R routing; an out-of-range ID is always accepted and dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rid_onehot_s[i] = (m_axi_rid == ID_W'(i));
        end
        rid_legal_s = (int'(m_axi_rid) < NUM_CH);
        rready_s    = !rid_legal_s || (|(rid_onehot_s & rd_data_ready_in));
        r_hs_s      = m_axi_rvalid && rready_s;
        r_last_hs_s = r_hs_s && m_axi_rlast;
        r_err_s     = r_hs_s && ((m_axi_rresp != 2'b00) || !rid_legal_s);
    end

    // Outstanding-burst credits; decrement clamps at zero for late beats after reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            outstanding_r <= '0;
        end else begin
            case ({ar_hs_s, r_last_hs_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
                2'b01:   outstanding_r <= (outstanding_r != '0) ? outstanding_r - OUT_W'(1) : '0;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Saturating error-beat counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_cnt_r <= 16'h0000;
        end else if (r_err_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'h0001;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign rd_req_ready_out  = req_ready_s;
    assign m_axi_arvalid     = arvalid_r;
    assign m_axi_araddr      = araddr_r;
    assign m_axi_arid        = arid_r;
    assign m_axi_arlen       = 8'(BURST_LEN - 1);
    assign m_axi_arsize      = 3'(SZ);
    assign m_axi_arburst     = 2'b01;
    assign m_axi_rready      = rready_s;
    assign rd_data_out       = m_axi_rdata;
    assign rd_data_last_out  = m_axi_rlast;
    assign rd_data_valid_out = m_axi_rvalid ? rid_onehot_s : '0;
    assign rd_err_count_out  = err_cnt_r;

endmodule
